// File: rtl/sync_ram_pkg.sv
// rtl/sync_ram_pkg.sv - shared constants, pointer-width helper and request bundle for sync_ram_req_port
package sync_ram_pkg;

    localparam int DWIDTH_DEFAULT = 32;
    localparam int AWIDTH_DEFAULT = 8;

    // Pointer width for a buffer of the given depth; never narrower than one bit.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Request bundle for callers that carry the request as a single word.
    typedef struct packed {
        logic                      we;
        logic [AWIDTH_DEFAULT-1:0] addr;
        logic [DWIDTH_DEFAULT-1:0] wdata;
    } sync_ram_req_t;

endpackage

// File: rtl/sync_ram_rsp_fifo.sv
// rtl/sync_ram_rsp_fifo.sv - synchronous response FIFO with push/pop/count, any depth
module sync_ram_rsp_fifo
    import sync_ram_pkg::*;
#(
    parameter int DWIDTH = DWIDTH_DEFAULT,
    parameter int DEPTH  = 4,
    parameter int PW     = ptr_width(DEPTH),
    parameter int CW     = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DWIDTH-1:0] push_data,
    input  logic              pop,
    output logic [DWIDTH-1:0] head_data,
    output logic [CW-1:0]     count
);

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic              do_pop;

    // Wrap at DEPTH rather than at a power of two.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Pops on an empty FIFO are ignored; pushes are trusted to have space (caller holds credits).
    assign do_pop    = pop & (count != '0);
    assign head_data = mem[rd_ptr];

    // Storage, pointers and occupancy; entries are cleared on reset so the head reads 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            count <= count + CW'(push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/sync_ram_req_port.sv
// rtl/sync_ram_req_port.sv - valid/ready request adapter for one block-RAM port; SYNC_RAM_WRITE_ACK_EN adds write acks
module sync_ram_req_port
    import sync_ram_pkg::*;
#(
    parameter int DWIDTH    = DWIDTH_DEFAULT,
    parameter int AWIDTH    = AWIDTH_DEFAULT,
    parameter int RSP_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [AWIDTH-1:0] req_addr,
    input  logic [DWIDTH-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DWIDTH-1:0] rsp_data,
    output logic [AWIDTH-1:0] ram_addr,
    output logic [DWIDTH-1:0] ram_d,
    output logic              ram_we,
    input  logic [DWIDTH-1:0] ram_q
);

    localparam int CW = $clog2(RSP_DEPTH + 1);

    logic [CW-1:0]     buf_count;
    logic [CW:0]       credit_used;
    logic              inflight;
    logic              fire;
    logic [DWIDTH-1:0] push_data;

    // A request is only accepted when a buffer slot is guaranteed for its response,
    // counting the one that may already be in the RAM pipeline.
    assign credit_used = {1'b0, buf_count} + (CW + 1)'(inflight);
    assign req_ready   = ~rst & (credit_used < (CW + 1)'(RSP_DEPTH));
    assign fire        = req_valid & req_ready;

    // RAM port follows the request bus; only the write strobe is qualified.
    assign ram_addr = req_addr;
    assign ram_d    = req_wdata;
    assign ram_we   = fire & req_we & ~rst;

`ifdef SYNC_RAM_WRITE_ACK_EN
    logic inflight_wr;

    // Every accepted request yields a response; remember whether it is a write ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight    <= 1'b0;
            inflight_wr <= 1'b0;
        end else begin
            inflight    <= fire;
            inflight_wr <= fire & req_we;
        end
    end

    assign push_data = inflight_wr ? '0 : ram_q;
`else
    // Only reads yield a response; RAM q is valid the cycle after the read fire.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight <= 1'b0;
        end else begin
            inflight <= fire & ~req_we;
        end
    end

    assign push_data = ram_q;
`endif

    sync_ram_rsp_fifo #(
        .DWIDTH (DWIDTH),
        .DEPTH  (RSP_DEPTH),
        .CW     (CW)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight),
        .push_data (push_data),
        .pop       (rsp_ready),
        .head_data (rsp_data),
        .count     (buf_count)
    );

    assign rsp_valid = (buf_count != '0);

endmodule
